// File: rtl/div_seq.sv
// Sequential 32-bit integer divider (DIV / DIVU), one restoring radix-2 step per cycle.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor completes in one step instead of 32.
module div_seq (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        annul,
    output logic        stall,
    output logic        ready,
    output logic [31:0] lo,
    output logic [31:0] hi
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

`ifdef DIV_ZERO_FAST_EN
    localparam logic FAST_ZERO = 1'b1;
`else
    localparam logic FAST_ZERO = 1'b0;
`endif

    localparam logic [5:0] LAST_STEP = 6'd32;

    state_t      state_q;
    logic [5:0]  count_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvsr_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic        zero_q;
    logic        ready_q;
    logic [31:0] lo_q;
    logic [31:0] hi_q;

    logic        accept;
    logic        zero_hit;
    logic [31:0] opa_mag;
    logic [31:0] opb_mag;
    logic [32:0] shifted_d;
    logic [32:0] diff_d;
    logic [31:0] rem_d;
    logic [31:0] quo_d;
    logic [31:0] lo_d;
    logic [31:0] hi_d;

    assign accept   = (state_q == IDLE) && start && !annul;
    assign zero_hit = FAST_ZERO && (opb == 32'd0);

    always_comb begin
        opa_mag = (signed_div && opa[31]) ? (32'd0 - opa) : opa;
        opb_mag = (signed_div && opb[31]) ? (32'd0 - opb) : opb;
    end

    // The dividend shifts out of quo_q's top while quotient bits shift in at the bottom.
    always_comb begin
        shifted_d = {rem_q, quo_q[31]};
        diff_d    = shifted_d - {1'b0, dvsr_q};
        rem_d     = diff_d[32] ? shifted_d[31:0] : diff_d[31:0];
        quo_d     = {quo_q[30:0], ~diff_d[32]};
    end

    always_comb begin
        lo_d = q_neg_q ? (32'd0 - quo_q) : quo_q;
        hi_d = r_neg_q ? (32'd0 - rem_q) : rem_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            count_q <= 6'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            dvsr_q  <= 32'd0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            zero_q  <= 1'b0;
            ready_q <= 1'b0;
            lo_q    <= 32'd0;
            hi_q    <= 32'd0;
        end else if (annul) begin
            state_q <= IDLE;
            count_q <= 6'd0;
            zero_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= BUSY;
                        rem_q   <= 32'd0;
                        dvsr_q  <= opb_mag;
                        if (zero_hit) begin
                            // Skip straight to the final step with the canned result.
                            count_q <= LAST_STEP;
                            quo_q   <= 32'hFFFF_FFFF;
                            rem_q   <= opa;
                            q_neg_q <= 1'b0;
                            r_neg_q <= 1'b0;
                            zero_q  <= 1'b1;
                        end else begin
                            count_q <= 6'd0;
                            quo_q   <= opa_mag;
                            q_neg_q <= signed_div && (opa[31] ^ opb[31]);
                            r_neg_q <= signed_div && opa[31];
                            zero_q  <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    if (count_q == LAST_STEP) begin
                        state_q <= DONE;
                        ready_q <= 1'b1;
                        lo_q    <= lo_d;
                        hi_q    <= hi_d;
                        zero_q  <= 1'b0;
                    end else begin
                        rem_q   <= rem_d;
                        quo_q   <= quo_d;
                        count_q <= count_q + 6'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    count_q <= 6'd0;
                end
                default: begin
                    state_q <= IDLE;
                    count_q <= 6'd0;
                end
            endcase
        end
    end

    assign stall = resetn && (accept || ((state_q == BUSY) && !zero_q));
    assign ready = ready_q;
    assign lo    = lo_q;
    assign hi    = hi_q;

endmodule
